ondra_tape_player: RTL and testbench

- Cassette waveform generator: the transmit direction of the MGF tape path.
- Takes a byte stream, typically a downloaded tape image fed by a loader from HPS ioctl, and encodes it as a 1-bit MGF square wave on clk_sys.
- Top level muxes the output onto the core's MGF_IN as an alternative to the ADC tape input.
- Playback is gated by the core's RELAY (motor) output, as on the real recorder.

---
 rtl/ondra_tape_player_if.sv | 10 +
 rtl/ondra_tape_player.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ondra_tape_player.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ondra_tape_player_if.sv
// Byte stream feeding the tape player: valid/ready handshake with a last-byte marker.
interface ondra_tape_player_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/ondra_tape_player.sv
// MGF cassette waveform generator: byte FIFO -> pilot, sync, LSB-first bit cells, trailing gap.
// Optional ONDRA_TAPE_CHKSUM_EN appends an 8-bit additive checksum byte after the last byte.
module ondra_tape_player #(
    parameter int FIFO_DEPTH  = 16,
    parameter int PILOT_HALF  = 3000,
    parameter int PILOT_COUNT = 2048,
    parameter int SYNC_HALF   = 1000,
    parameter int HALF0       = 2000,
    parameter int HALF1       = 4000,
    parameter int GAP_CYCLES  = 80000
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                motor,
    ondra_tape_player_if.slave  in_if,
    output logic                tape_out,
    output logic                busy,
    output logic                underrun,
    output logic [15:0]         byte_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int MAX_A = (PILOT_HALF > SYNC_HALF) ? PILOT_HALF : SYNC_HALF;
    localparam int MAX_B = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_N = (MAX_C > GAP_CYCLES) ? MAX_C : GAP_CYCLES;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam int HW_W  = $clog2(PILOT_COUNT + 1);

    typedef enum logic [2:0] {S_IDLE, S_PILOT, S_SYNC, S_DATA, S_GAP} state_e;

    // FIFO: in_last travels as bit 8 of each entry
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   fill_q;
    logic             push, pop, flush, fifo_empty;
    logic [8:0]       head;

    assign in_if.in_ready = (fill_q != (PTR_W + 1)'(FIFO_DEPTH));
    assign push           = in_if.in_valid & in_if.in_ready;
    assign fifo_empty     = (fill_q == '0);
    assign head           = mem_q[rd_ptr_q];

    // NOTE: the storage array is deliberately not reset; fill_q alone says which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= {in_if.in_last, in_if.in_data};
    end

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            fill_q <= fill_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
        end
    end

    state_e           state_q, state_d;
    logic             tape_q, tape_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HW_W-1:0]  halves_q, halves_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_q, bit_d;
    logic             phase_q, phase_d;
    logic             last_q, last_d;
    logic             stall_q, stall_d;
    logic             underrun_q, underrun_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic             load;
    logic [CNT_W-1:0] bit_end;
`ifdef ONDRA_TAPE_CHKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic             chk_q, chk_d;
`endif

    assign bit_end = shift_q[0] ? CNT_W'(HALF1 - 1) : CNT_W'(HALF0 - 1);

    always_comb begin
        // NOTE: every variable gets a default here so no path through the block infers a latch.
        state_d    = state_q;
        tape_d     = tape_q;
        cnt_d      = cnt_q;
        halves_d   = halves_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        last_d     = last_q;
        stall_d    = stall_q;
        underrun_d = underrun_q;
        byte_cnt_d = byte_cnt_q;
        pop        = 1'b0;
        flush      = 1'b0;
        load       = 1'b0;
`ifdef ONDRA_TAPE_CHKSUM_EN
        sum_d      = sum_q;
        chk_d      = chk_q;
`endif
        if (abort) begin
            state_d  = S_IDLE;
            tape_d   = 1'b0;
            cnt_d    = '0;
            halves_d = '0;
            stall_d  = 1'b0;
            flush    = 1'b1;
        end else if (state_q == S_IDLE) begin
            tape_d = 1'b0;
            if (start) begin
                state_d    = S_PILOT;
                cnt_d      = '0;
                halves_d   = '0;
                byte_cnt_d = '0;
                underrun_d = 1'b0;
`ifdef ONDRA_TAPE_CHKSUM_EN
                sum_d      = '0;
                chk_d      = 1'b0;
`endif
            end
        end else if (motor) begin
            case (state_q)
                S_PILOT: begin
                    if (cnt_q == CNT_W'(PILOT_HALF - 1)) begin
                        cnt_d  = '0;
                        tape_d = ~tape_q;
                        if (halves_q == HW_W'(PILOT_COUNT - 1)) begin
                            halves_d = '0;
                            state_d  = S_SYNC;
                        end else begin
                            halves_d = halves_q + HW_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SYNC: begin
                    if (cnt_q == CNT_W'(SYNC_HALF - 1)) begin
                        cnt_d  = '0;
                        tape_d = ~tape_q;
                        if (halves_q != '0) begin
                            halves_d = '0;
                            state_d  = S_DATA;
                            load     = 1'b1;
                        end else begin
                            halves_d = HW_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (stall_q) begin
                        load = 1'b1;
                    end else if (cnt_q == bit_end) begin
                        cnt_d   = '0;
                        tape_d  = ~tape_q;
                        phase_d = ~phase_q;
                        if (phase_q) begin
                            shift_d = {1'b0, shift_q[7:1]};
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                byte_cnt_d = byte_cnt_q + 16'd1;
`ifdef ONDRA_TAPE_CHKSUM_EN
                                if (chk_q) begin
                                    state_d = S_GAP;
                                end else if (last_q) begin
                                    chk_d   = 1'b1;
                                    shift_d = sum_q;
                                end else begin
                                    load = 1'b1;
                                end
`else
                                if (last_q) state_d = S_GAP;
                                else        load    = 1'b1;
`endif
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    tape_d = 1'b0;
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Fetch the next byte; an empty FIFO parks the waveform until data arrives
            if (load) begin
                cnt_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                if (fifo_empty) begin
                    stall_d    = 1'b1;
                    underrun_d = 1'b1;
                end else begin
                    pop     = 1'b1;
                    stall_d = 1'b0;
                    shift_d = head[7:0];
                    last_d  = head[8];
`ifdef ONDRA_TAPE_CHKSUM_EN
                    sum_d   = sum_q + head[7:0];
`endif
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tape_q     <= 1'b0;
            cnt_q      <= '0;
            halves_q   <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            last_q     <= 1'b0;
            stall_q    <= 1'b0;
            underrun_q <= 1'b0;
            byte_cnt_q <= '0;
`ifdef ONDRA_TAPE_CHKSUM_EN
            sum_q      <= '0;
            chk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tape_q     <= tape_d;
            cnt_q      <= cnt_d;
            halves_q   <= halves_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            last_q     <= last_d;
            stall_q    <= stall_d;
            underrun_q <= underrun_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef ONDRA_TAPE_CHKSUM_EN
            sum_q      <= sum_d;
            chk_q      <= chk_d;
`endif
        end
    end

    assign tape_out   = tape_q;
    assign busy       = (state_q != S_IDLE);
    assign underrun   = underrun_q;
    assign byte_count = byte_cnt_q;

endmodule

// File: tb/tb_ondra_tape_player.sv
// Self-checking bench for ondra_tape_player: waveform run lengths versus a segment-list model.
module tb_ondra_tape_player;
    localparam int FIFO_DEPTH  = 16;
    localparam int PILOT_HALF  = 4;
    localparam int PILOT_COUNT = 6;
    localparam int SYNC_HALF   = 2;
    localparam int HALF0       = 3;
    localparam int HALF1       = 5;
    localparam int GAP_CYCLES  = 10;
    localparam int BUDGET      = 3000;
`ifdef ONDRA_TAPE_CHKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset, start, abort, motor;
    logic        tape_out, busy, underrun;
    logic [15:0] byte_count;

    ondra_tape_player_if bus ();

    ondra_tape_player #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PILOT_HALF (PILOT_HALF),
        .PILOT_COUNT(PILOT_COUNT),
        .SYNC_HALF  (SYNC_HALF),
        .HALF0      (HALF0),
        .HALF1      (HALF1),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .motor     (motor),
        .in_if     (bus),
        .tape_out  (tape_out),
        .busy      (busy),
        .underrun  (underrun),
        .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    int         errors = 0;
    int         checks = 0;
    logic       samples[$];
    int         meas_segs[$];
    int         exp_segs[$];
    logic [7:0] blk[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: list of half-period lengths between level changes, starting low after start
    task automatic build_model();
        logic [7:0] bytes_q[$];
        logic [7:0] sum;
        bytes_q = blk;
        sum = 8'h00;
        foreach (blk[i]) sum = sum + blk[i];
`ifdef ONDRA_TAPE_CHKSUM_EN
        bytes_q.push_back(sum);
`endif
        exp_segs.delete();
        repeat (PILOT_COUNT) exp_segs.push_back(PILOT_HALF);
        repeat (2) exp_segs.push_back(SYNC_HALF);
        foreach (bytes_q[b])
            for (int i = 0; i < 8; i++)
                repeat (2) exp_segs.push_back(bytes_q[b][i] ? HALF1 : HALF0);
        exp_segs.push_back(GAP_CYCLES);
    endtask

    function automatic int byte_end(input int b);
        int s = 0;
        for (int k = 0; k < PILOT_COUNT + 2 + 16 * b + 16; k++) s += exp_segs[k];
        return s;
    endfunction

    // A stall covering edge e lengthens whichever half-period that edge belongs to
    task automatic extend_seg(input int e, input int n);
        int  cum = 0;
        bit  done = 0;
        for (int k = 0; k < exp_segs.size(); k++) begin
            cum += exp_segs[k];
            if (!done && cum >= e) begin
                exp_segs[k] += n;
                done = 1;
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk_sys);
        bus.in_valid = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
    endtask

    task automatic capture(input int motor_at, input int hold, input int abort_at,
                           output int ur_idx, output int push_idx);
        int n = 0;
        int changes = 0;
        ur_idx = -1;
        push_idx = -1;
        samples.delete();
        while (busy === 1'b1 && n < BUDGET) begin
            samples.push_back(tape_out);
            bus.in_valid = 1'b0;
            if (n == motor_at)     motor = 1'b0;
            if (n == motor_at + 7) motor = 1'b1;
            if (n == abort_at)     abort = 1'b1;
            if (hold >= 0) begin
                if (ur_idx < 0 && underrun === 1'b1) ur_idx = n;
                if (ur_idx >= 0 && n > ur_idx && n <= ur_idx + hold && tape_out !== samples[ur_idx])
                    changes++;
                if (ur_idx >= 0 && n == ur_idx + hold) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 8'hFF;
                    bus.in_last  = 1'b1;
                    push_idx     = n;
                end
            end
            n++;
            @(negedge clk_sys);
        end
        abort = 1'b0;
        bus.in_valid = 1'b0;
        motor = 1'b1;
        check("block finished within budget", 32'(busy), 0);
        if (hold >= 0) check("underrun tape frozen changes", changes, 0);
    endtask

    task automatic compare_wave(input string tag);
        meas_segs.delete();
        foreach (samples[i]) begin
            if (i == 0 || samples[i] !== samples[i-1]) meas_segs.push_back(1);
            else meas_segs[meas_segs.size() - 1] += 1;
        end
        check({tag, " start level"}, 32'(samples.size() > 0 ? samples[0] : 1'b1), 0);
        check({tag, " segment count"}, meas_segs.size(), exp_segs.size());
        for (int i = 0; i < exp_segs.size() && i < meas_segs.size(); i++)
            check($sformatf("%s seg%0d", tag, i), meas_segs[i], exp_segs[i]);
    endtask

    task automatic run_block(input string tag, input int motor_at);
        int ur, pi;
        foreach (blk[i]) push_byte(blk[i], i == blk.size() - 1);
        start_pulse();
        capture(motor_at, -1, -1, ur, pi);
        build_model();
        if (motor_at >= 0) extend_seg(motor_at + 1, 7);
        compare_wave(tag);
        check({tag, " byte_count"}, 32'(byte_count), blk.size() + CHK_BYTES);
    endtask

    initial begin
        int         ur, pi, acc, a, m, sd, mism, pilot_sum, exp_bc;
        logic [7:0] b;
        logic       lvl_q[$];
        logic       lvl;

        reset = 1'b1; start = 1'b0; abort = 1'b0; motor = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("reset tape_out", 32'(tape_out), 0);
        check("reset busy", 32'(busy), 0);
        check("reset underrun", 32'(underrun), 0);
        check("reset byte_count", 32'(byte_count), 0);
        check("reset in_ready", 32'(bus.in_ready), 1);
        reset = 1'b0;
        @(negedge clk_sys);

        blk.delete(); blk.push_back(8'h00);
        run_block("pilot", -1);

        blk.delete(); blk.push_back(8'hA5); blk.push_back(8'h01);
        run_block("bits", -1);

        blk.delete();
        repeat (3) blk.push_back(8'($urandom));
        run_block("random", -1);

        blk.delete(); blk.push_back(8'($urandom));
        m = $urandom_range(3, 20);
        run_block("motor", m);
        pilot_sum = 0;
        for (int i = 0; i < PILOT_COUNT && i < meas_segs.size(); i++) pilot_sum += meas_segs[i];
        check("motor pilot length", pilot_sum, PILOT_COUNT * PILOT_HALF + 7);

        blk.delete(); blk.push_back(8'($urandom)); blk.push_back(8'hFF);
        push_byte(blk[0], 1'b0);
        start_pulse();
        capture(-1, 20, -1, ur, pi);
        build_model();
        sd = byte_end(0);
        check("underrun onset index", ur, sd);
        exp_segs[PILOT_COUNT + 2 + 16] += (pi + 2) - sd;
        compare_wave("underrun");
        check("underrun sticky", 32'(underrun), 1);
        check("underrun byte_count", 32'(byte_count), 2 + CHK_BYTES);

        blk.delete(); blk.push_back(8'h80); blk.push_back(8'h81);
        run_block("chksum", -1);

        acc = 0;
        blk.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            if (bus.in_ready === 1'b1) begin
                acc++;
                blk.push_back(b);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            bus.in_last  = 1'b0;
            @(negedge clk_sys);
        end
        bus.in_valid = 1'b0;
        check("fifo accepted count", acc, FIFO_DEPTH);
        check("fifo full in_ready", 32'(bus.in_ready), 0);
        a = PILOT_COUNT * PILOT_HALF + 2 * SYNC_HALF + $urandom_range(20, 120);
        start_pulse();
        capture(-1, -1, a, ur, pi);
        build_model();
        exp_bc = 0;
        for (int k = 0; k < blk.size(); k++) if (byte_end(k) <= a) exp_bc++;
        lvl = 1'b0;
        lvl_q.delete();
        foreach (exp_segs[k]) begin
            repeat (exp_segs[k]) lvl_q.push_back(lvl);
            lvl = ~lvl;
        end
        mism = 0;
        for (int i = 0; i < samples.size() && i <= a; i++) if (samples[i] !== lvl_q[i]) mism++;
        check("abort waveform prefix mismatches", mism, 0);
        check("abort stop index", samples.size(), a + 1);
        check("abort tape_out", 32'(tape_out), 0);
        check("abort in_ready", 32'(bus.in_ready), 1);
        check("abort byte_count retained", 32'(byte_count), exp_bc);
        check("abort underrun retained", 32'(underrun), 0);

        blk.delete(); blk.push_back(8'h5A);
        run_block("flush", -1);

        b = 8'($urandom);
        push_byte(b, 1'b0);
        start_pulse();
        for (int i = 0; i < BUDGET && underrun !== 1'b1; i++) @(negedge clk_sys);
        check("pre-reset underrun", 32'(underrun), 1);
        check("pre-reset byte_count", 32'(byte_count), 1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("mid reset tape_out", 32'(tape_out), 0);
        check("mid reset busy", 32'(busy), 0);
        check("mid reset underrun", 32'(underrun), 0);
        check("mid reset byte_count", 32'(byte_count), 0);
        check("mid reset in_ready", 32'(bus.in_ready), 1);
        reset = 1'b0;
        @(negedge clk_sys);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
